// File: rtl/apb_uart_fifo.sv
// APB-controlled UART with TX/RX FIFOs and a programmable baud divisor.
// Define APB_UART_PARITY_EN to add an even-parity bit to every frame.
module apb_uart_fifo_q #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // a full FIFO still takes a push when a pop frees a slot in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module apb_uart_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        rxd,
    output logic        txd
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_st_e;

    logic              acc_wr, acc_rd;
    logic [15:0]       div_q;
    logic              overrun, parity_err, frame_err;
    logic              tx_push, tx_pop, tx_full, tx_empty, tx_load, tx_end;
    logic              rx_push, rx_pop, rx_full, rx_empty, rx_half, rx_end;
    logic [DATA_W-1:0] tx_head, rx_head;

    uart_st_e          tx_st, tx_st_n, rx_st, rx_st_n;
    logic [15:0]       tx_cnt, tx_cnt_n, tx_bdiv, tx_bdiv_n, rx_cnt, rx_cnt_n, rx_bdiv, rx_bdiv_n;
    logic [DATA_W-1:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
    logic [2:0]        tx_bit, tx_bit_n, rx_bit, rx_bit_n;
    logic              tx_par, tx_par_n, txd_n, rx_perr, rx_perr_n;
    logic              rx_s1, rx_s2, rx_prev, ovr_set, perr_set, ferr_set;

    assign pready = 1'b1;
    assign acc_wr = psel && penable && pwrite;
    assign acc_rd = psel && penable && !pwrite;
    assign tx_push = acc_wr && (paddr == 4'h4);
    assign rx_pop  = acc_rd && (paddr == 4'h8) && !rx_empty;

    apb_uart_fifo_q #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_txq (
        .clk(clk), .rst(rst), .push(tx_push), .wdata(pwdata[DATA_W-1:0]), .pop(tx_pop),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty));
    apb_uart_fifo_q #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rxq (
        .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty));

    always_comb begin
        prdata = '0;
        if (acc_rd) begin
            case (paddr)
                4'h0:    prdata = {24'd0, frame_err, tx_st != IDLE, parity_err, overrun,
                                   rx_empty, rx_full, tx_empty, tx_full};
                4'h8:    prdata = rx_empty ? '0 : 32'(rx_head);
                4'hC:    prdata = {16'd0, div_q};
                default: prdata = '0;
            endcase
        end
    end

    assign pslverr = (tx_push && tx_full && !tx_pop) || (acc_rd && paddr == 4'h8 && rx_empty) ||
                     (acc_wr && paddr == 4'h8) || (acc_rd && paddr == 4'h4);

    // TX: each bit's length is latched at its boundary so DIV writes land cleanly
    assign tx_end = (tx_cnt == tx_bdiv - 16'd1);
    always_comb begin
        tx_st_n = tx_st; tx_cnt_n = tx_cnt + 16'd1; tx_bdiv_n = tx_bdiv; tx_sh_n = tx_sh;
        tx_bit_n = tx_bit; tx_par_n = tx_par; txd_n = txd; tx_pop = 1'b0; tx_load = 1'b0;
        case (tx_st)
            IDLE: begin tx_cnt_n = '0; tx_load = !tx_empty; end
            START: if (tx_end) begin
                tx_st_n = DATA; tx_cnt_n = '0; tx_bdiv_n = div_q;
                txd_n = tx_sh[0]; tx_sh_n = tx_sh >> 1; tx_bit_n = '0;
            end
            DATA: if (tx_end) begin
                tx_cnt_n = '0; tx_bdiv_n = div_q;
                if (tx_bit == 3'(DATA_W-1)) begin
`ifdef APB_UART_PARITY_EN
                    tx_st_n = PARITY; txd_n = tx_par;
`else
                    tx_st_n = STOP; txd_n = 1'b1;
`endif
                end else begin
                    tx_bit_n = tx_bit + 1'b1; txd_n = tx_sh[0]; tx_sh_n = tx_sh >> 1;
                end
            end
            PARITY: if (tx_end) begin
                tx_st_n = STOP; tx_cnt_n = '0; tx_bdiv_n = div_q; txd_n = 1'b1;
            end
            STOP: if (tx_end) begin
                tx_st_n = IDLE; tx_cnt_n = '0; txd_n = 1'b1; tx_load = !tx_empty;
            end
            default: tx_st_n = IDLE;
        endcase
        if (tx_load) begin
            tx_pop = 1'b1; tx_st_n = START; tx_cnt_n = '0; tx_bdiv_n = div_q;
            txd_n = 1'b0; tx_sh_n = tx_head; tx_par_n = ^tx_head;
        end
    end

    // RX: start bit checked at mid-bit, later bits every DIV from there
    assign rx_half = (rx_cnt == (rx_bdiv >> 1) - 16'd1);
    assign rx_end  = (rx_cnt == rx_bdiv - 16'd1);
    always_comb begin
        rx_st_n = rx_st; rx_cnt_n = rx_cnt + 16'd1; rx_bdiv_n = rx_bdiv; rx_sh_n = rx_sh;
        rx_bit_n = rx_bit; rx_perr_n = rx_perr; rx_push = 1'b0; ferr_set = 1'b0; perr_set = 1'b0;
        case (rx_st)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) begin rx_st_n = START; rx_bdiv_n = div_q; end
            end
            START: if (rx_half) begin
                rx_st_n = rx_s2 ? IDLE : DATA; rx_cnt_n = '0; rx_bdiv_n = div_q;
                rx_bit_n = '0; rx_perr_n = 1'b0;
            end
            DATA: if (rx_end) begin
                rx_cnt_n = '0; rx_bdiv_n = div_q; rx_sh_n = {rx_s2, rx_sh[DATA_W-1:1]};
                if (rx_bit == 3'(DATA_W-1)) begin
`ifdef APB_UART_PARITY_EN
                    rx_st_n = PARITY;
`else
                    rx_st_n = STOP;
`endif
                end else rx_bit_n = rx_bit + 1'b1;
            end
            PARITY: if (rx_end) begin
                rx_st_n = STOP; rx_cnt_n = '0; rx_bdiv_n = div_q; rx_perr_n = rx_s2 ^ (^rx_sh);
            end
            STOP: if (rx_end) begin
                rx_st_n = IDLE; rx_cnt_n = '0;
                if (!rx_s2) ferr_set = 1'b1;
                else begin rx_push = 1'b1; perr_set = rx_perr; end
            end
            default: rx_st_n = IDLE;
        endcase
    end
    assign ovr_set = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st <= IDLE; tx_cnt <= '0; tx_bdiv <= 16'(DIV_RESET); tx_sh <= '0; tx_bit <= '0;
            tx_par <= 1'b0; txd <= 1'b1;
            rx_st <= IDLE; rx_cnt <= '0; rx_bdiv <= 16'(DIV_RESET); rx_sh <= '0; rx_bit <= '0;
            rx_perr <= 1'b0; rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            div_q <= 16'(DIV_RESET); overrun <= 1'b0; parity_err <= 1'b0; frame_err <= 1'b0;
        end else begin
            tx_st <= tx_st_n; tx_cnt <= tx_cnt_n; tx_bdiv <= tx_bdiv_n; tx_sh <= tx_sh_n;
            tx_bit <= tx_bit_n; tx_par <= tx_par_n; txd <= txd_n;
            rx_st <= rx_st_n; rx_cnt <= rx_cnt_n; rx_bdiv <= rx_bdiv_n; rx_sh <= rx_sh_n;
            rx_bit <= rx_bit_n; rx_perr <= rx_perr_n;
            rx_s1 <= rxd; rx_s2 <= rx_s1; rx_prev <= rx_s2;
            if (acc_wr && paddr == 4'hC) div_q <= (pwdata[15:0] < 16'd2) ? 16'd2 : pwdata[15:0];
            // a new event in the same cycle as its clear wins
            overrun   <= (overrun    & ~(acc_wr && paddr == 4'h0 && pwdata[4])) | ovr_set;
            frame_err <= (frame_err  & ~(acc_wr && paddr == 4'h0 && pwdata[7])) | ferr_set;
`ifdef APB_UART_PARITY_EN
            parity_err <= (parity_err & ~(acc_wr && paddr == 4'h0 && pwdata[5])) | perr_set;
`else
            parity_err <= 1'b0;
`endif
        end
    end
endmodule
